// File: rtl/snn_pkg.sv
// Shared types for the SNN training datapath: scheduler FSM states,
// default weight width and the signed weight type.
package snn_pkg;

   localparam int WUS_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } wus_state_e;

   typedef logic signed [WUS_DATA_W-1:0] weight_t;

endpackage

// File: rtl/wus_pipe_stage.sv
// One valid/address/spike delay slot of the weight-update pipeline.
// A flush drops the valid so the entry can never turn into a write.
module wus_pipe_stage
   import snn_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              spike_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              spike_o
);

   logic              valid_q;
   logic [ADDR_W-1:0] addr_q;
   logic              spike_q;

   // Delay register for one in-flight entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         addr_q  <= {ADDR_W{1'b0}};
         spike_q <= 1'b0;
      end else begin
         valid_q <= valid_i & ~flush_i;
         addr_q  <= addr_i;
         spike_q <= spike_i;
      end
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign spike_o = spike_q;

endmodule

// File: rtl/weight_update_scheduler.sv
// Walks weight/gradient memory once per start, feeds the optimizer and writes
// its result back. Optional macro WUS_SKIP_QUIET_EN suppresses writes for spike=0.
module weight_update_scheduler
   import snn_pkg::*;
#(
   parameter int N_WEIGHTS = 16,
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = WUS_DATA_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [N_WEIGHTS-1:0] spike_mask,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted,
   output logic [ADDR_W:0]      update_cnt,
   output logic                 rd_en,
   output logic [ADDR_W-1:0]    rd_addr,
   input  logic [DATA_W-1:0]    rd_weight,
   input  logic [DATA_W-1:0]    rd_grad,
   output logic                 opt_spike,
   output logic [DATA_W-1:0]    opt_weight,
   output logic [DATA_W-1:0]    opt_grad,
   input  logic [DATA_W-1:0]    opt_weight_out,
   output logic                 wr_en,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [DATA_W-1:0]    wr_data
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WEIGHTS - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

   wus_state_e           state_q;
   logic                 rd_en_q;
   logic [ADDR_W-1:0]    rd_addr_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 aborted_q;
   logic [N_WEIGHTS-1:0] mask_q;
   logic [ADDR_W:0]      cnt_q;

   logic                 s1_valid_s;
   logic [ADDR_W-1:0]    s1_addr_s;
   logic                 s1_spike_s;
   logic                 s2_valid_in_s;
   logic                 s2_valid_s;
   logic [ADDR_W-1:0]    s2_addr_s;
   logic                 s2_spike_s;
   logic                 accept_s;
   logic                 abort_take_s;
   logic                 drain_clear_s;

   assign accept_s     = (state_q == IDLE) & start;
   assign abort_take_s = abort & ((state_q == RUN) | (state_q == DRAIN));
   // Both valids will be clear after this edge: no read issued, stage 1 empty.
   assign drain_clear_s = ~rd_en_q & ~s1_valid_s;

`ifdef WUS_SKIP_QUIET_EN
   assign s2_valid_in_s = s1_valid_s & s1_spike_s;
`else
   assign s2_valid_in_s = s1_valid_s;
`endif

   wus_pipe_stage #(.ADDR_W(ADDR_W)) u_stage1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (abort_take_s),
      .valid_i (rd_en_q),
      .addr_i  (rd_addr_q),
      .spike_i (mask_q[rd_addr_q]),
      .valid_o (s1_valid_s),
      .addr_o  (s1_addr_s),
      .spike_o (s1_spike_s)
   );

   wus_pipe_stage #(.ADDR_W(ADDR_W)) u_stage2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (abort_take_s),
      .valid_i (s2_valid_in_s),
      .addr_i  (s1_addr_s),
      .spike_i (s1_spike_s),
      .valid_o (s2_valid_s),
      .addr_o  (s2_addr_s),
      .spike_o (s2_spike_s)
   );

   // Sweep sequencer with registered strobes and status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rd_en_q   <= 1'b0;
         rd_addr_q <= {ADDR_W{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         mask_q    <= {N_WEIGHTS{1'b0}};
      end else if (abort_take_s) begin
         state_q   <= DONE;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b1;
         aborted_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= RUN;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= {ADDR_W{1'b0}};
                  busy_q    <= 1'b1;
                  aborted_q <= 1'b0;
                  mask_q    <= spike_mask;
               end
            end
            RUN: begin
               if (rd_addr_q == LAST_ADDR) begin
                  state_q <= DRAIN;
                  rd_en_q <= 1'b0;
               end else begin
                  rd_addr_q <= rd_addr_q + ADDR_ONE;
               end
            end
            DRAIN: begin
               if (drain_clear_s) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               rd_en_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Count completed spiking writes; a write ending on the abort edge still counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {(ADDR_W + 1){1'b0}};
      end else if (accept_s) begin
         cnt_q <= {(ADDR_W + 1){1'b0}};
      end else if (s2_valid_s & s2_spike_s) begin
         cnt_q <= cnt_q + CNT_ONE;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign update_cnt = cnt_q;
   assign rd_en      = rd_en_q;
   assign rd_addr    = rd_addr_q;
   assign opt_spike  = s1_spike_s;
   assign opt_weight = rd_weight;
   assign opt_grad   = rd_grad;
   assign wr_en      = s2_valid_s;
   assign wr_addr    = s2_addr_s;
   assign wr_data    = opt_weight_out;

endmodule
